// File: rtl/bus_arbiter_rr.sv
// Round-robin arbiter for one shared bus: holds a grant until the owner releases
// it, then leaves a turnaround gap before the next owner may drive.
module bus_arbiter_rr #(
    parameter int N_MASTERS         = 4,
    parameter int TURNAROUND_CYCLES = 1,
    parameter int MAX_HOLD          = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [N_MASTERS-1:0]         req,
    input  logic                         mem_ready,
    output logic [N_MASTERS-1:0]         grant,
    output logic                         bus_busy,
    output logic [$clog2(N_MASTERS)-1:0] grant_idx,
    output logic                         timeout
);
    localparam int IW = $clog2(N_MASTERS);
    localparam int TW = $clog2(TURNAROUND_CYCLES + 1);
    localparam logic [IW-1:0] LAST_RESET = IW'(N_MASTERS - 1);
    localparam logic [TW-1:0] TURN_MAX   = TW'(TURNAROUND_CYCLES);
    localparam logic [15:0]   HOLD_MAX   = 16'(MAX_HOLD);

    typedef enum logic [2:0] {
        IDLE  = 3'b001,
        GRANT = 3'b010,
        TURN  = 3'b100
    } state_t;

    state_t               state, state_next;
    logic [N_MASTERS-1:0] grant_next;
    logic                 bus_busy_next;
    logic                 timeout_next;
    logic [IW-1:0]        grant_idx_next;
    logic [15:0]          hold_cnt, hold_next;
    logic [TW-1:0]        turn_cnt, turn_next;
    logic                 any_req;
    logic [IW-1:0]        winner;

    assign any_req = |req;

    // grant_idx doubles as the round-robin pointer. Scanning from the far end
    // lets the nearest requester after the pointer overwrite all others.
    always_comb begin
        int            idx;
        logic [IW-1:0] pos;
        winner = grant_idx;
        idx    = 0;
        pos    = '0;
        for (int k = N_MASTERS; k >= 1; k--) begin
            idx = int'(grant_idx) + k;
            if (idx >= N_MASTERS) idx = idx - N_MASTERS;
            pos = IW'(idx);
            if (req[pos]) winner = pos;
        end
    end

    always_comb begin
        state_next     = state;
        grant_next     = grant;
        bus_busy_next  = bus_busy;
        grant_idx_next = grant_idx;
        timeout_next   = 1'b0;
        hold_next      = hold_cnt;
        turn_next      = turn_cnt;
        case (state)
            IDLE: begin
                grant_next    = '0;
                bus_busy_next = 1'b0;
                if (any_req) begin
                    state_next     = GRANT;
                    grant_next     = N_MASTERS'(1) << winner;
                    bus_busy_next  = 1'b1;
                    grant_idx_next = winner;
                    hold_next      = 16'd1;
                end
            end
            GRANT: begin
                if (!req[grant_idx]) begin
                    state_next    = TURN;
                    grant_next    = '0;
                    bus_busy_next = 1'b0;
                    turn_next     = TW'(1);
                end else if (MAX_HOLD != 0 && hold_cnt == HOLD_MAX) begin
                    state_next    = TURN;
                    grant_next    = '0;
                    bus_busy_next = 1'b0;
                    turn_next     = TW'(1);
                    timeout_next  = 1'b1;
                end else if (hold_cnt != 16'hFFFF) begin
                    hold_next = hold_cnt + 16'd1;
                end
            end
            TURN: begin
                grant_next    = '0;
                bus_busy_next = 1'b0;
                // The old owner must be off the bus and memory idle before handover.
                if (turn_cnt >= TURN_MAX && !mem_ready) begin
                    if (any_req) begin
                        state_next     = GRANT;
                        grant_next     = N_MASTERS'(1) << winner;
                        bus_busy_next  = 1'b1;
                        grant_idx_next = winner;
                        hold_next      = 16'd1;
                    end else begin
                        state_next = IDLE;
                    end
                end else if (turn_cnt < TURN_MAX) begin
                    turn_next = turn_cnt + TW'(1);
                end
            end
            default: begin
                state_next    = IDLE;
                grant_next    = '0;
                bus_busy_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            grant     <= '0;
            bus_busy  <= 1'b0;
            grant_idx <= LAST_RESET;
            timeout   <= 1'b0;
            hold_cnt  <= '0;
            turn_cnt  <= '0;
        end else begin
            state     <= state_next;
            grant     <= grant_next;
            bus_busy  <= bus_busy_next;
            grant_idx <= grant_idx_next;
            timeout   <= timeout_next;
            hold_cnt  <= hold_next;
            turn_cnt  <= turn_next;
        end
    end
endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Bench for bus_arbiter_rr: two instances (short gap / no timeout, long gap / timeout)
// driven with the same inputs and compared every cycle against an owner-level model.
module tb_bus_arbiter_rr;
    localparam int N = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req;
    logic       mem_ready;

    logic [3:0] grant_a, grant_b;
    logic       busy_a, busy_b;
    logic [1:0] idx_a, idx_b;
    logic       to_a, to_b;

    int checks   = 0;
    int failures = 0;

    // Model: who owns the bus, the pointer, how long the owner has held it,
    // and how far into the post-release gap we are.
    int m_owner[2];
    int m_last[2];
    int m_hold[2];
    int m_gap[2];
    bit m_gapping[2];
    bit m_to[2];
    int tc_p[2] = '{1, 2};
    int mh_p[2] = '{0, 8};

    bus_arbiter_rr #(.N_MASTERS(4), .TURNAROUND_CYCLES(1), .MAX_HOLD(0)) dut_a (
        .clk(clk), .reset(reset), .req(req), .mem_ready(mem_ready),
        .grant(grant_a), .bus_busy(busy_a), .grant_idx(idx_a), .timeout(to_a)
    );

    bus_arbiter_rr #(.N_MASTERS(4), .TURNAROUND_CYCLES(2), .MAX_HOLD(8)) dut_b (
        .clk(clk), .reset(reset), .req(req), .mem_ready(mem_ready),
        .grant(grant_b), .bus_busy(busy_b), .grant_idx(idx_b), .timeout(to_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [3:0] r, input int last);
        for (int k = 1; k <= N; k++) begin
            if (r[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset(input int i);
        m_owner[i]   = -1;
        m_last[i]    = N - 1;
        m_hold[i]    = 0;
        m_gap[i]     = 0;
        m_gapping[i] = 1'b0;
        m_to[i]      = 1'b0;
    endtask

    task automatic award(input int i);
        int w;
        w = pick(req, m_last[i]);
        if (w >= 0) begin
            m_owner[i] = w;
            m_last[i]  = w;
            m_hold[i]  = 1;
        end
    endtask

    task automatic model_step(input int i);
        if (reset) begin
            model_reset(i);
        end else begin
            m_to[i] = 1'b0;
            if (m_owner[i] >= 0) begin
                if (!req[m_owner[i]]) begin
                    m_owner[i] = -1; m_gapping[i] = 1'b1; m_gap[i] = 1;
                end else if (mh_p[i] != 0 && m_hold[i] >= mh_p[i]) begin
                    m_owner[i] = -1; m_gapping[i] = 1'b1; m_gap[i] = 1; m_to[i] = 1'b1;
                end else if (m_hold[i] < 65535) begin
                    m_hold[i]++;
                end
            end else if (m_gapping[i]) begin
                if (m_gap[i] >= tc_p[i] && !mem_ready) begin
                    m_gapping[i] = 1'b0;
                    award(i);
                end else if (m_gap[i] < tc_p[i]) begin
                    m_gap[i]++;
                end
            end else begin
                award(i);
            end
        end
    endtask

    task automatic check_inst(input string t, input logic [3:0] g, input logic b,
                              input logic [1:0] x, input logic to, input int i);
        logic [3:0] exp_g;
        exp_g = (m_owner[i] >= 0) ? (4'b0001 << m_owner[i]) : 4'b0000;
        check({t, "_grant"},   32'(g),  32'(exp_g));
        check({t, "_busy"},    32'(b),  32'(m_owner[i] >= 0));
        check({t, "_idx"},     32'(x),  32'(m_last[i]));
        check({t, "_timeout"}, 32'(to), 32'(m_to[i]));
        check({t, "_onehot"},  32'($countones(g) <= 1), 32'(1));
    endtask

    task automatic check_all();
        check_inst("a", grant_a, busy_a, idx_a, to_a, 0);
        check_inst("b", grant_b, busy_b, idx_b, to_b, 1);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0);
        model_step(1);
        @(negedge clk);
        check_all();
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int own;
        int nxt;
        reset     = 1'b1;
        req       = 4'b1111;
        mem_ready = 1'b0;
        model_reset(0);
        model_reset(1);

        // Reset held with every request raised.
        repeat (5) begin
            tick();
            check("rst_grant", 32'(grant_a), 32'(4'b0000));
            check("rst_busy", 32'(busy_a), 32'(0));
            check("rst_idx", 32'(idx_a), 32'(3));
        end
        reset = 1'b0;
        tick();
        check("first_grant", 32'(grant_a), 32'(4'b0001));
        check("first_idx", 32'(idx_a), 32'(0));
        req = 4'b0000;
        repeat (4) tick();

        // Single master holds for ten cycles, then releases.
        req = 4'b0100;
        tick();
        check("single_grant", 32'(grant_a), 32'(4'b0100));
        repeat (9) begin
            tick();
            check("single_hold", 32'(grant_a), 32'(4'b0100));
        end
        req = 4'b0000;
        tick();
        check("single_release", 32'(grant_a), 32'(4'b0000));
        check("single_busy", 32'(busy_a), 32'(0));
        tick();
        req = 4'b1000;
        tick();
        check("idle_regrant", 32'(grant_a), 32'(4'b1000));
        req = 4'b0000;
        repeat (3) tick();

        // Rotation with all masters requesting.
        apply_reset();
        req = 4'b1111;
        tick();
        check("rot_grant", 32'(grant_a), 32'(4'b0001));
        for (int k = 0; k < 5; k++) begin
            own = k % N;
            nxt = (k + 1) % N;
            tick();
            tick();
            req[own] = 1'b0;
            tick();
            check("rot_gap", 32'(grant_a), 32'(4'b0000));
            req = 4'b1111;
            tick();
            check("rot_grant", 32'(grant_a), 32'(4'b0001 << nxt));
        end
        req = 4'b0000;
        repeat (4) tick();

        // Memory still busy when the owner releases.
        apply_reset();
        req = 4'b0010;
        tick();
        check("stall_owner", 32'(grant_a), 32'(4'b0010));
        tick();
        req       = 4'b0100;
        mem_ready = 1'b1;
        tick();
        check("stall_release", 32'(grant_a), 32'(4'b0000));
        repeat (4) begin
            tick();
            check("stall_hold", 32'(grant_a), 32'(4'b0000));
        end
        mem_ready = 1'b0;
        tick();
        check("stall_handover", 32'(grant_a), 32'(4'b0100));
        check("stall_idx", 32'(idx_a), 32'(2));
        req = 4'b0000;
        repeat (4) tick();

        // Hung master 0 on the instance with an 8-cycle hold limit and 2-cycle gap.
        apply_reset();
        req = 4'b0011;
        repeat (8) begin
            tick();
            check("to_hold", 32'(grant_b), 32'(4'b0001));
            check("to_quiet", 32'(to_b), 32'(0));
        end
        tick();
        check("to_revoke", 32'(grant_b), 32'(4'b0000));
        check("to_pulse", 32'(to_b), 32'(1));
        tick();
        check("to_gap", 32'(grant_b), 32'(4'b0000));
        check("to_single_pulse", 32'(to_b), 32'(0));
        tick();
        check("to_next", 32'(grant_b), 32'(4'b0010));
        check("to_next_idx", 32'(idx_b), 32'(1));
        repeat (3) begin
            tick();
            check("to_next_hold", 32'(grant_b), 32'(4'b0010));
        end
        req = 4'b0001;
        tick();
        check("to_rel_gap", 32'(grant_b), 32'(4'b0000));
        tick();
        check("to_rel_gap", 32'(grant_b), 32'(4'b0000));
        tick();
        check("to_regrant", 32'(grant_b), 32'(4'b0001));
        req = 4'b0000;
        repeat (4) tick();

        // Reset arriving between edges while master 2 owns the bus.
        apply_reset();
        req = 4'b0100;
        tick();
        check("mid_owner", 32'(grant_a), 32'(4'b0100));
        tick();
        #2;
        reset = 1'b1;
        #1;
        model_reset(0);
        model_reset(1);
        check("async_grant_a", 32'(grant_a), 32'(4'b0000));
        check("async_grant_b", 32'(grant_b), 32'(4'b0000));
        check("async_busy_a", 32'(busy_a), 32'(0));
        check("async_idx_a", 32'(idx_a), 32'(3));
        tick();
        reset = 1'b0;
        tick();
        check("post_reset_a", 32'(grant_a), 32'(4'b0100));
        check("post_reset_b", 32'(grant_b), 32'(4'b0100));

        // Random requests, memory stalls and occasional resets.
        req = 4'b0000;
        for (int c = 0; c < 800; c++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 5) == 0) req[b] = ~req[b];
            end
            mem_ready = ($urandom_range(0, 3) == 0);
            reset     = ($urandom_range(0, 249) == 0);
            tick();
        end
        reset = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
